// File: rtl/invader_march_ctrl.sv
// invader_march_ctrl
// Moves the invader formation's top-left corner. The formation marches right,
// drops, marches left, drops, and repeats. Positions are kept in signed
// fixed-point with FRAC_BITS fraction bits and reported in whole pixels.
//
// Ports
//   clk           system clock
//   reset         synchronous reset, active-high
//   startOfFrame  one-cycle pulse per frame; the only time motion happens
//   enable        leave idle and start marching
//   pause         freeze state and position (edge hits and restart still act)
//   restart       one-cycle pulse: back to the initial position, idle
//   chgDir        one-cycle pulse from collision logic: formation edge hit
//   speedLevel    requested march speed level (saturated to NUM_LEVELS-1)
//   topLeftX/Y    formation position in pixels, registered
//   dirRight      1 = current or upcoming horizontal direction is right
//   descending    1 while dropping
//   landed        1 once the formation has reached the floor
module invader_march_ctrl #(
  parameter int INIT_X       = 20,
  parameter int INIT_Y       = 20,
  parameter int FRAC_BITS    = 6,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 620,
  parameter int FLOOR_Y      = 400,
  parameter int DROP_PIX     = 8,
  parameter int Y_SPEED      = 64,
  parameter int BASE_X_SPEED = 60,
  parameter int SPEED_STEP   = 20,
  parameter int NUM_LEVELS   = 4,
  localparam int LW          = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          startOfFrame,
  input  logic          enable,
  input  logic          pause,
  input  logic          restart,
  input  logic          chgDir,
  input  logic [LW-1:0] speedLevel,
  output logic [10:0]   topLeftX,
  output logic [10:0]   topLeftY,
  output logic          dirRight,
  output logic          descending,
  output logic          landed
);

  localparam logic signed [31:0] Scale  = 32'sd1 <<< FRAC_BITS;
  localparam logic signed [31:0] InitXS = INIT_X * Scale;
  localparam logic signed [31:0] InitYS = INIT_Y * Scale;
  localparam logic signed [31:0] XMinS  = X_MIN * Scale;
  localparam logic signed [31:0] XMaxS  = X_MAX * Scale;
  localparam logic signed [31:0] FloorS = FLOOR_Y * Scale;
  localparam logic signed [31:0] DropS  = DROP_PIX * Scale;

  typedef enum logic [2:0] {
    StIdle,
    StMovR,
    StDropL,
    StMovL,
    StDropR,
    StLanded
  } stateT;

  stateT              state, stateNext;
  logic signed [31:0] posX, posXNext;
  logic signed [31:0] posY, posYNext;
  logic signed [31:0] dropAcc, dropAccNext;
  logic               hitFlag, hitFlagNext;
  logic               dirRightNext;

  int                 levelSat;
  logic signed [31:0] xSpeed;
  logic signed [31:0] xSum, xDiff, xRight, xLeft;
  logic signed [31:0] ySum, accSum;
  logic               inMove;

  always_comb begin
    if (int'(speedLevel) > NUM_LEVELS - 1) begin
      levelSat = NUM_LEVELS - 1;
    end else begin
      levelSat = int'(speedLevel);
    end
    xSpeed = BASE_X_SPEED + levelSat * SPEED_STEP;
    xSum   = posX + xSpeed;
    xDiff  = posX - xSpeed;
    xRight = (xSum >= XMaxS) ? XMaxS : xSum;
    xLeft  = (xDiff <= XMinS) ? XMinS : xDiff;
    ySum   = posY + Y_SPEED;
    accSum = dropAcc + Y_SPEED;
    inMove = (state == StMovR) || (state == StMovL);
  end

  always_comb begin
    stateNext    = state;
    posXNext     = posX;
    posYNext     = posY;
    dropAccNext  = dropAcc;
    hitFlagNext  = hitFlag;
    dirRightNext = dirRight;

    // Hits are latched only while marching, paused or not.
    if (chgDir && inMove) begin
      hitFlagNext = 1'b1;
    end

    if (startOfFrame && !pause) begin
      unique case (state)
        StIdle: begin
          if (enable) begin
            stateNext = StMovR;
          end
        end
        StMovR: begin
          posXNext = xRight;
          if (posY >= FloorS) begin
            stateNext   = StLanded;
            hitFlagNext = 1'b0;
          end else if (xRight >= XMaxS || hitFlag) begin
            stateNext    = StDropL;
            dropAccNext  = '0;
            dirRightNext = 1'b0;
            hitFlagNext  = 1'b0;
          end
        end
        StMovL: begin
          posXNext = xLeft;
          if (posY >= FloorS) begin
            stateNext   = StLanded;
            hitFlagNext = 1'b0;
          end else if (xLeft <= XMinS || hitFlag) begin
            stateNext    = StDropR;
            dropAccNext  = '0;
            dirRightNext = 1'b1;
            hitFlagNext  = 1'b0;
          end
        end
        StDropL, StDropR: begin
          posYNext    = ySum;
          dropAccNext = accSum;
          if (ySum >= FloorS) begin
            stateNext = StLanded;
          end else if (accSum >= DropS) begin
            // Overshoot past the drop depth is kept on purpose.
            stateNext = (state == StDropL) ? StMovL : StMovR;
          end
        end
        StLanded: begin
        end
        default: begin
          stateNext = StIdle;
        end
      endcase
    end

    if (restart) begin
      stateNext    = StIdle;
      posXNext     = InitXS;
      posYNext     = InitYS;
      dropAccNext  = '0;
      hitFlagNext  = 1'b0;
      dirRightNext = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StIdle;
      posX     <= InitXS;
      posY     <= InitYS;
      dropAcc  <= '0;
      hitFlag  <= 1'b0;
      dirRight <= 1'b1;
      topLeftX <= 11'(InitXS >>> FRAC_BITS);
      topLeftY <= 11'(InitYS >>> FRAC_BITS);
    end else begin
      state    <= stateNext;
      posX     <= posXNext;
      posY     <= posYNext;
      dropAcc  <= dropAccNext;
      hitFlag  <= hitFlagNext;
      dirRight <= dirRightNext;
      // Loaded from next-state so pixels appear one cycle after the frame pulse.
      topLeftX <= 11'(posXNext >>> FRAC_BITS);
      topLeftY <= 11'(posYNext >>> FRAC_BITS);
    end
  end

  always_comb begin
    descending = (state == StDropL) || (state == StDropR);
    landed     = (state == StLanded);
  end

endmodule

// File: tb/tb_invader_march_ctrl.sv
module tb_invader_march_ctrl;

  localparam int Scale   = 64;
  localparam int InitX   = 20;
  localparam int InitY   = 20;
  localparam int XMin    = 0;
  localparam int XMax    = 620;
  localparam int FloorY  = 400;
  localparam int DropPix = 8;
  localparam int YSpeed  = 64;
  localparam int Levels  = 4;

  localparam int PhIdle    = 0;
  localparam int PhMarch   = 1;
  localparam int PhDrop    = 2;
  localparam int PhLanded  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        enable = 1'b0;
  logic        pause = 1'b0;
  logic        restart = 1'b0;
  logic        chgDir = 1'b0;
  logic [1:0]  speedLevel = 2'd0;
  logic [10:0] topLeftX, topLeftY;
  logic        dirRight, descending, landed;

  int nCompared = 0;
  int nMismatched = 0;

  // Reference model: a phase, a heading and remaining drop distance.
  int mPhase = PhIdle;
  bit mRight = 1'b1;
  int mX = InitX * Scale;
  int mY = InitY * Scale;
  int mDropLeft = 0;
  bit mHit = 1'b0;

  invader_march_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .enable       (enable),
    .pause        (pause),
    .restart      (restart),
    .chgDir       (chgDir),
    .speedLevel   (speedLevel),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .dirRight     (dirRight),
    .descending   (descending),
    .landed       (landed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelUpdate();
    int  xs;
    int  lv;
    bit  atEdge;
    bit  hitNow;
    if (reset || restart) begin
      mPhase    = PhIdle;
      mRight    = 1'b1;
      mX        = InitX * Scale;
      mY        = InitY * Scale;
      mDropLeft = 0;
      mHit      = 1'b0;
      return;
    end
    hitNow = chgDir && (mPhase == PhMarch);
    if (startOfFrame && !pause) begin
      lv = int'(speedLevel);
      if (lv > Levels - 1) lv = Levels - 1;
      xs = 60 + lv * 20;
      case (mPhase)
        PhIdle: if (enable) mPhase = PhMarch;
        PhMarch: begin
          if (mRight) begin
            mX = (mX + xs > XMax * Scale) ? XMax * Scale : mX + xs;
            atEdge = (mX == XMax * Scale);
          end else begin
            mX = (mX - xs < XMin * Scale) ? XMin * Scale : mX - xs;
            atEdge = (mX == XMin * Scale);
          end
          if (mY >= FloorY * Scale) begin
            mPhase = PhLanded;
            mHit   = 1'b0;
          end else if (atEdge || mHit) begin
            mPhase    = PhDrop;
            mRight    = !mRight;
            mDropLeft = DropPix * Scale;
            mHit      = 1'b0;
          end else if (hitNow) begin
            mHit = 1'b1;
          end
        end
        PhDrop: begin
          mY        += YSpeed;
          mDropLeft -= YSpeed;
          if (mY >= FloorY * Scale) mPhase = PhLanded;
          else if (mDropLeft <= 0) mPhase = PhMarch;
        end
        default: ;
      endcase
    end else if (hitNow) begin
      mHit = 1'b1;
    end
  endtask

  task automatic checkAll();
    check("topLeftX", topLeftX, 11'(mX / Scale));
    check("topLeftY", topLeftY, 11'(mY / Scale));
    check("dirRight", {10'd0, dirRight}, {10'd0, mRight});
    check("descending", {10'd0, descending}, {10'd0, mPhase == PhDrop});
    check("landed", {10'd0, landed}, {10'd0, mPhase == PhLanded});
  endtask

  task automatic tick();
    @(posedge clk);
    modelUpdate();
    #1;
    checkAll();
  endtask

  // One frame: pulse, then `gap` quiet cycles; optional edge hit right after the pulse.
  task automatic frame(input int gap, input bit chgMid);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    for (int i = 0; i < gap; i++) begin
      chgDir = chgMid && (i == 0);
      tick();
    end
    chgDir = 1'b0;
  endtask

  initial begin
    int savedX;
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("resetX", topLeftX, 11'd20);
    check("resetDir", {10'd0, dirRight}, 11'd1);
    reset = 1'b0;
    tick();

    // Level 0 march: 10 frames of 60/64 px
    enable = 1'b1;
    speedLevel = 2'd0;
    frame(3, 1'b0);
    for (int i = 0; i < 10; i++) frame(3, 1'b0);
    check("march10X", topLeftX, 11'd29);
    check("march10Y", topLeftY, 11'd20);

    // Level 3 to the right bound, then an 8-frame drop
    speedLevel = 2'd3;
    for (int i = 0; i < 400 && mPhase != PhDrop; i++) frame(2, 1'b0);
    check("edgeDrop", {10'd0, descending}, 11'd1);
    check("edgeClampX", topLeftX, 11'd620);
    check("edgeDirLeft", {10'd0, dirRight}, 11'd0);
    for (int i = 0; i < 7; i++) frame(2, 1'b0);
    check("drop7Still", {10'd0, descending}, 11'd1);
    frame(2, 1'b0);
    check("drop8Done", {10'd0, descending}, 11'd0);
    check("drop8Y", topLeftY, 11'd28);

    // Hit mid-frame in MOV_L turns at the next frame; hit during drop ignored
    for (int i = 0; i < 3; i++) frame(3, 1'b0);
    frame(3, 1'b1);
    frame(3, 1'b0);
    check("hitTurn", {10'd0, descending}, 11'd1);
    check("hitDirRight", {10'd0, dirRight}, 11'd1);
    frame(3, 1'b1);
    for (int i = 0; i < 7; i++) frame(3, 1'b0);
    check("dropRDone", {10'd0, descending}, 11'd0);
    check("dropRY", topLeftY, 11'd36);
    frame(3, 1'b0);
    check("dropHitIgnored", {10'd0, descending}, 11'd0);

    // Pause freezes; a hit taken while paused turns at the first live frame
    savedX = mX / Scale;
    pause = 1'b1;
    for (int i = 0; i < 5; i++) frame(3, i == 2);
    check("pauseX", topLeftX, 11'(savedX));
    check("pauseNoDrop", {10'd0, descending}, 11'd0);
    pause = 1'b0;
    frame(3, 1'b0);
    check("pauseHitTurn", {10'd0, descending}, 11'd1);
    for (int i = 0; i < 8; i++) frame(3, 1'b0);

    // Random march until the floor is reached
    for (int i = 0; i < 4000 && mPhase != PhLanded; i++) begin
      speedLevel = 2'($urandom_range(0, 3));
      pause = ($urandom_range(0, 9) == 0);
      frame(int'($urandom_range(1, 4)), $urandom_range(0, 2) == 0);
    end
    pause = 1'b0;
    check("landedFlag", {10'd0, landed}, 11'd1);
    check("landedY", topLeftY, 11'd400);
    for (int i = 0; i < 3; i++) frame(2, 1'b1);
    check("landedHold", {10'd0, landed}, 11'd1);

    // Restart from landed
    enable = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restartX", topLeftX, 11'd20);
    check("restartY", topLeftY, 11'd20);
    check("restartLanded", {10'd0, landed}, 11'd0);
    frame(2, 1'b0);
    check("idleHoldX", topLeftX, 11'd20);

    // Top speed, then reset in the middle of a drop
    enable = 1'b1;
    speedLevel = 2'd3;
    for (int i = 0; i < 4; i++) frame(2, 1'b0);
    frame(2, 1'b1);
    frame(2, 1'b0);
    frame(2, 1'b0);
    check("preResetDrop", {10'd0, descending}, 11'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midDropResetX", topLeftX, 11'd20);
    check("midDropResetY", topLeftY, 11'd20);
    check("midDropResetDesc", {10'd0, descending}, 11'd0);
    check("midDropResetDir", {10'd0, dirRight}, 11'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
